lut_config_loader: RTL and testbench
====================================

# lut_config_loader

Serial-to-parallel configuration loader for the fracturable LUT tiles. It accepts a bit-serial configuration stream over a valid/ready handshake and assembles the LUT's parallel configuration word `{use_fracture, first_lut, second_lut}`. When the word is complete it drives `config_in` together with a single-cycle `comb_set` strobe. It is the writer side of the LUT configuration interface and sits between the chip-level config chain and each LUT's `config_in`/`comb_set` ports.

## Interface
- `INPUTS`, 4, LUT input count per half; must match the target LUT.
- `MEM_SIZE`, 2**INPUTS, truth-table bits per half LUT.
- `CFG_WIDTH`, 2*MEM_SIZE+1, configuration word width (33 at defaults); bit CFG_WIDTH-1 is the fracture bit.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  one-cycle request to begin a new load.
- `cfg_valid`  in  1  serial data qualifier.
- `cfg_data`  in  1  serial configuration bit; the first accepted bit becomes the MSB.
- `cfg_ready`  out  1  loader accepts `cfg_data` this cycle.
- `config_in`  out  CFG_WIDTH  parallel configuration word to the LUT.
- `comb_set`  out  1  LUT configuration write strobe, one cycle.
- `busy`  out  1  high in SHIFT or COMMIT.
- `load_done`  out  1  one-cycle pulse, coincident with `comb_set`.
- `aborted`  out  1  one-cycle pulse when a load is restarted before completion.

## Operation
- States:
  - IDLE: `cfg_ready`=0; `cfg_valid` is ignored.
  - SHIFT: `cfg_ready`=1.
  - COMMIT: `cfg_ready`=0, `comb_set`=1.
- IDLE -> SHIFT: on `cfg_start`. Bit counter clears to 0. `config_in` is not cleared; it holds the previous word until shifting overwrites it.
- SHIFT, bit accept:
  - A bit is accepted on a rising edge with `cfg_valid & cfg_ready`.
  - Shift left: `config_in <= {config_in[CFG_WIDTH-2:0], cfg_data}`.
  - Counter increments. Counter width is clog2(CFG_WIDTH+1).
- SHIFT -> COMMIT: on the edge that accepts bit number CFG_WIDTH (counter reaches CFG_WIDTH-1 then accepts).
- COMMIT -> IDLE: unconditionally after one cycle.
  - `comb_set`, `load_done` and `busy` are high for exactly that cycle.
  - The counter returns to 0.
- Restart during SHIFT: `cfg_start` asserted in SHIFT (with or without `cfg_valid`) takes priority.
  - The concurrent bit is discarded and the counter clears.
  - State stays SHIFT; `aborted` pulses the next cycle.
  - No `comb_set` is issued for the abandoned load.
- `cfg_start` during COMMIT is ignored; the commit always completes.
- `config_in` changes only on accepted bits. It is stable throughout COMMIT and IDLE. The LUT samples it only under `comb_set`, so intermediate values are harmless.
- Asynchronous reset (`rst_n`=0):
  - IDLE, counter 0, `config_in`=0, all outputs 0.
  - Reset mid-load discards the partial word and produces no `comb_set`.

## Timing
- Reset values: `config_in`=0, `cfg_ready`=0, `comb_set`=0, `busy`=0, `load_done`=0, `aborted`=0.
- `cfg_start` sampled at edge E0 -> `cfg_ready`=1 and `busy`=1 from E0 onward.
- With `cfg_valid` held high, bit i is accepted at edge E0+i (i=1..CFG_WIDTH).
  - `comb_set` is high in the cycle after edge E0+CFG_WIDTH.
  - `busy` drops after edge E0+CFG_WIDTH+1.
- Minimum load-to-load spacing: CFG_WIDTH+2 cycles (start, CFG_WIDTH bits, commit).
- `cfg_valid` gaps stall the counter with no penalty beyond the gap length.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then `cfg_start` and stream 33'h1AAAA5555 MSB-first with `cfg_valid` always high:
  - `config_in`=33'h1AAAA5555 when `comb_set`=1.
  - `comb_set` and `load_done` high exactly one cycle, 34 cycles after start.
- Same word with `cfg_valid` deasserted every other cycle:
  - Identical final `config_in`.
  - `comb_set` at 67 cycles after start.
  - `cfg_ready` stays 1 through the gaps.
- Shift 10 bits, pulse `cfg_start`, then stream 33'h000000001:
  - `aborted` pulses once.
  - Exactly one `comb_set`, with `config_in`=33'h000000001.
- Drop `rst_n` after 20 bits:
  - All outputs 0 immediately (asynchronous).
  - No `comb_set`.
  - Next full load 33'h0FFFF0000 commits correctly.
- In IDLE, toggle `cfg_valid` and `cfg_data` for 50 cycles:
  - `config_in` unchanged, `cfg_ready`=0, no strobes.
- Back-to-back loads 33'h100000000 then 33'h0DEADBEEF, with `cfg_start` asserted in the COMMIT cycle and again in IDLE:
  - The COMMIT-cycle start is ignored.
  - Two `comb_set` pulses with the correct words, spaced ≥35 cycles.

Source files
------------

// File: rtl/lut_config_loader_if.sv
// rtl/lut_config_loader_if.sv - bit-serial configuration stream handshake
//
// Carries the serial side of the LUT configuration loader.
//   cfg_start : one-cycle request to begin a new load (master -> slave)
//   cfg_valid : serial data qualifier                 (master -> slave)
//   cfg_data  : serial configuration bit, MSB first   (master -> slave)
//   cfg_ready : slave accepts cfg_data this cycle     (slave -> master)
interface lut_config_loader_if;
  logic cfg_start;
  logic cfg_valid;
  logic cfg_data;
  logic cfg_ready;

  modport master (
    output cfg_start,
    output cfg_valid,
    output cfg_data,
    input  cfg_ready
  );

  modport slave (
    input  cfg_start,
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready
  );
endinterface

// File: rtl/lut_config_loader.sv
// rtl/lut_config_loader.sv - serial-to-parallel fracturable LUT configuration loader
//
// Shifts a bit-serial configuration stream into the LUT's parallel word
// {use_fracture, first_lut, second_lut} and strobes comb_set once the word
// is complete.
//   clk, rst_n : clock and asynchronous active-low reset
//   cfg        : serial stream (cfg_start, cfg_valid, cfg_data, cfg_ready)
//   config_in  : parallel configuration word to the LUT (MSB = fracture bit)
//   comb_set   : one-cycle LUT configuration write strobe
//   busy       : high while shifting or committing
//   load_done  : one-cycle pulse coincident with comb_set
//   aborted    : one-cycle pulse after a load is restarted mid-shift
module lut_config_loader #(
  parameter int INPUTS    = 4,
  parameter int MEM_SIZE  = 2**INPUTS,
  parameter int CFG_WIDTH = 2*MEM_SIZE+1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  lut_config_loader_if.slave   cfg,
  output logic [CFG_WIDTH-1:0] config_in,
  output logic                 comb_set,
  output logic                 busy,
  output logic                 load_done,
  output logic                 aborted
);

  localparam int CNT_W = $clog2(CFG_WIDTH+1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             restart;
  logic             cnt_clr;
  logic             last_bit;

  assign last_bit = (bit_cnt == CNT_W'(CFG_WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    restart   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg.cfg_start) begin
          state_nxt = S_SHIFT;
          cnt_clr   = 1'b1;
        end
      end
      S_SHIFT: begin
        // A restart wins over a concurrent bit; that bit is dropped.
        if (cfg.cfg_start) begin
          restart = 1'b1;
          cnt_clr = 1'b1;
        end else if (cfg.cfg_valid) begin
          accept = 1'b1;
          if (last_bit) begin
            state_nxt = S_COMMIT;
            cnt_clr   = 1'b1;
          end
        end
      end
      S_COMMIT: begin
        state_nxt = S_IDLE;
        cnt_clr   = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  // Datapath: config_in only moves on accepted bits, so it holds the last
  // committed word through COMMIT and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      config_in <= '0;
    end else begin
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (accept) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (accept) begin
        config_in <= {config_in[CFG_WIDTH-2:0], cfg.cfg_data};
      end
    end
  end

  // Status outputs are registered from the next state so that they line up
  // with the state they describe and have no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg.cfg_ready <= 1'b0;
      busy          <= 1'b0;
      comb_set      <= 1'b0;
      load_done     <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      cfg.cfg_ready <= (state_nxt == S_SHIFT);
      busy          <= (state_nxt != S_IDLE);
      comb_set      <= (state_nxt == S_COMMIT);
      load_done     <= (state_nxt == S_COMMIT);
      aborted       <= restart;
    end
  end

endmodule

// File: tb/tb_lut_config_loader.sv
// tb/tb_lut_config_loader.sv - scoreboard testbench for lut_config_loader
module tb_lut_config_loader;
  localparam int CW = 33;
  localparam int P  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(P/2) clk = ~clk;

  lut_config_loader_if cfg_if();
  logic [CW-1:0] config_in;
  logic          comb_set;
  logic          busy;
  logic          load_done;
  logic          aborted;

  lut_config_loader #(.INPUTS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (cfg_if.slave),
    .config_in (config_in),
    .comb_set  (comb_set),
    .busy      (busy),
    .load_done (load_done),
    .aborted   (aborted)
  );

  int checks = 0;
  int errors = 0;
  logic [CW-1:0] exp_q[$];
  int  n_commits    = 0;
  int  abort_cycles = 0;
  int  exp_aborts   = 0;
  time last_cs_time = 0;
  time prev_cs_time = 0;
  time t0           = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every comb_set pops the next expected word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (comb_set) begin
        logic [CW-1:0] w;
        n_commits++;
        prev_cs_time = last_cs_time;
        last_cs_time = $time;
        if (exp_q.size() == 0) begin
          chk("unexpected_comb_set", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("config_in_at_comb_set", config_in, w);
        end
        chk("load_done_with_comb_set", load_done, 1);
        chk("busy_in_commit", busy, 1);
        chk("ready_in_commit", cfg_if.cfg_ready, 0);
      end else begin
        chk("load_done_without_comb_set", load_done, 0);
      end
      if (aborted) abort_cycles++;
    end
  end

  // Start a load and stream nbits of w MSB first.
  // gap_mode: 0 = valid always high, 1 = one idle cycle before every bit,
  // 2 = random idle cycles.
  task automatic send_bits(input logic [CW-1:0] w, input int nbits, input int gap_mode);
    int g;
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_valid = 1'($urandom % 2);
    cfg_if.cfg_data  = 1'($urandom % 2);
    @(posedge clk);
    t0 = $time;
    #1;
    cfg_if.cfg_start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int j = 0; j < g; j++) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_data  = 1'($urandom % 2);
        @(negedge clk);
        if (gap_mode == 1) chk("ready_during_gap", cfg_if.cfg_ready, 1);
        @(posedge clk);
        #1;
      end
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_data  = w[CW-1-i];
      @(posedge clk);
      #1;
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [CW-1:0] w, input int gap_mode);
    exp_q.push_back(w);
    send_bits(w, CW, gap_mode);
  endtask

  // Wait (bounded) until n_commits reaches target; exp_k is the edge index
  // after start whose edge raises comb_set, or -1 to skip the latency check.
  task automatic wait_commit(input int target, input int exp_k, input string name);
    int n;
    n = 0;
    while (n_commits < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_commit_seen"}, (n_commits >= target), 1);
    if (n_commits >= target && exp_k >= 0)
      chk({name, "_latency"}, int'((last_cs_time - t0 - P/2) / P), exp_k);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int ab0;
    logic [CW-1:0] held;
    logic [CW-1:0] w;

    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_config_in", config_in, 0);
    chk("reset_cfg_ready", cfg_if.cfg_ready, 0);
    chk("reset_comb_set", comb_set, 0);
    chk("reset_busy", busy, 0);
    chk("reset_load_done", load_done, 0);
    chk("reset_aborted", aborted, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous load.
    base = n_commits;
    load(33'h1AAAA5555, 0);
    wait_commit(base + 1, CW, "contig");

    // Valid deasserted every other cycle.
    base = n_commits;
    load(33'h1AAAA5555, 1);
    wait_commit(base + 1, 2*CW, "gapped");

    // Restart after 10 bits.
    base = n_commits;
    ab0  = abort_cycles;
    send_bits(CW'({$urandom, $urandom}), 10, 0);
    exp_aborts++;
    load(33'h000000001, 0);
    wait_commit(base + 1, CW, "restart");
    chk("aborted_once", abort_cycles - ab0, 1);

    // Reset after 20 bits.
    base = n_commits;
    send_bits(33'h155555555, 20, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_config_in", config_in, 0);
    chk("async_rst_cfg_ready", cfg_if.cfg_ready, 0);
    chk("async_rst_comb_set", comb_set, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_load_done", load_done, 0);
    chk("async_rst_aborted", aborted, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("no_commit_after_reset", n_commits, base);
    load(33'h0FFFF0000, 0);
    wait_commit(base + 1, CW, "post_reset");

    // Idle noise.
    held = config_in;
    for (int i = 0; i < 50; i++) begin
      cfg_if.cfg_valid = 1'($urandom % 2);
      cfg_if.cfg_data  = 1'($urandom % 2);
      @(negedge clk);
      chk("idle_cfg_ready", cfg_if.cfg_ready, 0);
      chk("idle_config_in", config_in, held);
      chk("idle_busy", busy, 0);
      @(posedge clk);
      #1;
    end
    cfg_if.cfg_valid = 1'b0;

    // Back-to-back with a start during COMMIT.
    base = n_commits;
    load(33'h100000000, 0);
    cfg_if.cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.cfg_start = 1'b0;
    chk("commit_start_ignored_busy", busy, 0);
    chk("commit_start_ignored_ready", cfg_if.cfg_ready, 0);
    load(33'h0DEADBEEF, 0);
    wait_commit(base + 2, CW, "b2b");
    chk("b2b_spacing_ge_35", (int'((last_cs_time - prev_cs_time) / P) >= 35), 1);

    // Randomized loads with random gaps and occasional restarts.
    for (int r = 0; r < 8; r++) begin
      base = n_commits;
      if ($urandom % 3 == 0) begin
        send_bits(CW'({$urandom, $urandom}), int'($urandom_range(1, CW-1)), 2);
        exp_aborts++;
      end
      w = CW'({$urandom, $urandom});
      load(w, 2);
      wait_commit(base + 1, -1, "random");
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("abort_pulse_count", abort_cycles, exp_aborts);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
